stopwatch_core: RTL and testbench
=================================

# stopwatch_core

Millisecond stopwatch datapath and control that consumes the 1 kHz single-cycle tick from the clock divider and keeps an mm:ss.mmm BCD count. Start/stop, clear and lap controls come from debounced, single-cycle button pulses. The registered 7-digit BCD output feeds the seven-segment display driver directly.

## Interface
- `WRAP`, default 1: 1 = roll over 59:59.999 -> 00:00.000 and keep running; 0 = saturate at 59:59.999 and pause.
- `clk` in 1: 50 MHz system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick_ms` in 1: one-cycle strobe at 1 kHz, synchronous to `clk`.
- `start_stop` in 1: one-cycle pulse that toggles between run and pause.
- `clear` in 1: one-cycle pulse that zeroes the count and returns to idle.
- `lap` in 1: one-cycle pulse that toggles the display freeze while running.
- `disp_bcd` out 28: {min_t, min_o, sec_t, sec_o, ms_h, ms_t, ms_o}, 4 bits each, registered.
- `running` out 1: high in RUN.
- `lap_hold` out 1: high while the display is frozen.
- `overflow` out 1: sticky; set on rollover or saturation.

## Operation
- Internal count: seven BCD digits with moduli 10, 10, 10, 10, 6, 10, 6 (ms_o up to min_t).
- A digit increments when its carry-in is high. Carry-out = carry-in AND the digit is at modulus-1. At carry-out the digit wraps to 0.
- Carry chain is combinational within one cycle. Carry-in of ms_o is `tick_ms` AND state==RUN.
- States:
  - IDLE: count 0, stopped.
  - RUN: counting.
  - PAUSE: count held.
- Transitions:
  - IDLE --start_stop--> RUN
  - RUN --start_stop--> PAUSE
  - PAUSE --start_stop--> RUN
  - any state --clear--> IDLE
  - RUN --saturation (WRAP=0)--> PAUSE
- Priority: clear > start_stop > lap.
  - `clear` zeroes the count, drops `lap_hold` and clears `overflow`.
  - When `clear` is asserted, `start_stop` and `lap` in the same cycle are ignored.
- Lap:
  - In RUN, `lap` toggles `lap_hold`.
  - While `lap_hold`=1, `disp_bcd` keeps its value but the internal count continues.
  - On release, `disp_bcd` resumes tracking the count.
  - `lap` is ignored in IDLE and PAUSE.
  - `lap_hold` is forced to 0 on any RUN->PAUSE transition.
- Rollover at 59:59.999 with a tick:
  - WRAP=1: count becomes 0, `overflow` set, state stays RUN.
  - WRAP=0: count stays at 59:59.999, `overflow` set, state -> PAUSE.
- Invalid BCD values cannot arise: digits are only written with 0 or digit+1 below the modulus.

## Timing
- Reset values: state IDLE, count 0, `disp_bcd`=0, `running`=0, `lap_hold`=0, `overflow`=0.
- Reset takes effect immediately, mid-count included.
- Tick latency:
  - A `tick_ms` sampled at edge N in RUN updates both count and `disp_bcd` at edge N (visible in cycle N+1), unless `lap_hold` is set.
  - State is evaluated before its transition. A tick coincident with start_stop in RUN is counted. A tick coincident with start_stop in IDLE or PAUSE is not counted.
  - A tick coincident with `clear` is dropped; count is 0 after the edge.
- `running` and `lap_hold` are registered and change on the same edge as the state.
- `overflow` is set on the same edge as the rollover or saturation.
- Back-to-back pulses on consecutive cycles are all honoured. No minimum spacing is required.

## Structure
- Shared package `timer_pkg`:
  - state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2)
  - digit width 4
  - digit moduli (10, 6)
  - `DISP_W`=28
- Sub-module `bcd_digit`:
  - parameter `MOD`
  - inputs clk, rst_n, clr, cin
  - outputs q[3:0], cout
  - instantiated 7 times in the carry chain.
- Top level holds the FSM, the lap register, the overflow flag and the display register.

## Test plan
- Reset, start_stop, then 1000 ticks -> `disp_bcd` = 00:01.000 (0x0001000), `running`=1.
- RUN at 00:09.999, one tick -> 00:10.000. RUN at 00:59.999, one tick -> 01:00.000.
- start_stop, 5 ticks, start_stop, 5 ticks, start_stop, 5 ticks -> 00:00.010 and state RUN.
- RUN at 00:00.100, lap, 250 ticks -> `disp_bcd` stays 00:00.100. Lap again -> next cycle shows 00:00.350.
- WRAP=1 at 59:59.999, tick -> 00:00.000 and `overflow`=1. WRAP=0, same stimulus -> holds 59:59.999, `overflow`=1, `running`=0.
- Simultaneous events:
  - clear+start_stop+tick in RUN -> IDLE, count 0.
  - rst_n pulsed low mid-count -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the stopwatch: FSM encoding, BCD digit
// geometry and the packed display width.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  localparam int DIGIT_W    = 4;
  localparam int MOD_DEC    = 10;
  localparam int MOD_SEX    = 6;
  localparam int NUM_DIGITS = 7;
  localparam int DISP_W     = 28;

  // Digit 0 is ms_o; the tens-of-seconds and tens-of-minutes digits count to 6.
  function automatic int digit_mod(input int idx);
    int m;
    case (idx)
      4:       m = MOD_SEX;
      6:       m = MOD_SEX;
      default: m = MOD_DEC;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Control pulses into the stopwatch and its display/status outputs.
interface stopwatch_core_if;
  import timer_pkg::*;

  logic              tick_ms;
  logic              start_stop;
  logic              clear;
  logic              lap;
  logic [DISP_W-1:0] disp_bcd;
  logic              running;
  logic              lap_hold;
  logic              overflow;

  modport master (
    output tick_ms, start_stop, clear, lap,
    input  disp_bcd, running, lap_hold, overflow
  );

  modport slave (
    input  tick_ms, start_stop, clear, lap,
    output disp_bcd, running, lap_hold, overflow
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD counter digit of modulus MOD in a ripple carry chain; also exposes
// its next value so the parent can register the display on the same edge.
module bcd_digit
  import timer_pkg::*;
#(
  parameter int MOD = MOD_DEC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               cin,
  output logic [DIGIT_W-1:0] q,
  output logic [DIGIT_W-1:0] q_nxt,
  output logic               cout
);

  logic [DIGIT_W-1:0] q_q, q_d;

  assign cout = cin & (q_q == DIGIT_W'(MOD - 1));

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (cout) begin
      q_d = '0;
    end else if (cin) begin
      q_d = q_q + 4'd1;
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign q_nxt = q_d;

endmodule

// File: rtl/stopwatch_core.sv
// mm:ss.mmm stopwatch: seven-digit BCD carry chain, run/pause FSM, lap freeze
// of the display and a sticky overflow flag.
module stopwatch_core
  import timer_pkg::*;
#(
  parameter bit WRAP = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  stopwatch_core_if.slave bus
);

  sw_state_e         state_q, state_d;
  logic              lap_hold_q, lap_hold_d;
  logic              overflow_q, overflow_d;
  logic              running_q, running_d;
  logic [DISP_W-1:0] disp_q, disp_d;

  logic [DIGIT_W-1:0]  dig_q   [NUM_DIGITS];
  logic [DIGIT_W-1:0]  dig_nxt [NUM_DIGITS];
  logic [NUM_DIGITS:0] carry_s;
  logic [NUM_DIGITS-1:0] at_max_s;
  logic              run_s;
  logic              count_max_s;
  logic              sat_evt_s;
  logic              roll_evt_s;
  logic [DISP_W-1:0] count_nxt_s;

  assign run_s = (state_q == ST_RUN);

  always_comb begin
    at_max_s    = '0;
    count_nxt_s = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      at_max_s[i] = (dig_q[i] == DIGIT_W'(digit_mod(i) - 1));
      count_nxt_s[i*DIGIT_W +: DIGIT_W] = dig_nxt[i];
    end
  end

  // In saturate mode the tick is swallowed at 59:59.999 so the count holds.
  assign count_max_s = &at_max_s;
  assign sat_evt_s   = ~WRAP & bus.tick_ms & run_s & count_max_s;
  assign carry_s[0]  = bus.tick_ms & run_s & ~sat_evt_s;
  assign roll_evt_s  = carry_s[NUM_DIGITS] | sat_evt_s;

  bcd_digit #(.MOD(MOD_DEC)) u_ms_o (
    .clk(clk), .rst_n(rst_n), .clr(bus.clear), .cin(carry_s[0]),
    .q(dig_q[0]), .q_nxt(dig_nxt[0]), .cout(carry_s[1])
  );
  bcd_digit #(.MOD(MOD_DEC)) u_ms_t (
    .clk(clk), .rst_n(rst_n), .clr(bus.clear), .cin(carry_s[1]),
    .q(dig_q[1]), .q_nxt(dig_nxt[1]), .cout(carry_s[2])
  );
  bcd_digit #(.MOD(MOD_DEC)) u_ms_h (
    .clk(clk), .rst_n(rst_n), .clr(bus.clear), .cin(carry_s[2]),
    .q(dig_q[2]), .q_nxt(dig_nxt[2]), .cout(carry_s[3])
  );
  bcd_digit #(.MOD(MOD_DEC)) u_sec_o (
    .clk(clk), .rst_n(rst_n), .clr(bus.clear), .cin(carry_s[3]),
    .q(dig_q[3]), .q_nxt(dig_nxt[3]), .cout(carry_s[4])
  );
  bcd_digit #(.MOD(MOD_SEX)) u_sec_t (
    .clk(clk), .rst_n(rst_n), .clr(bus.clear), .cin(carry_s[4]),
    .q(dig_q[4]), .q_nxt(dig_nxt[4]), .cout(carry_s[5])
  );
  bcd_digit #(.MOD(MOD_DEC)) u_min_o (
    .clk(clk), .rst_n(rst_n), .clr(bus.clear), .cin(carry_s[5]),
    .q(dig_q[5]), .q_nxt(dig_nxt[5]), .cout(carry_s[6])
  );
  bcd_digit #(.MOD(MOD_SEX)) u_min_t (
    .clk(clk), .rst_n(rst_n), .clr(bus.clear), .cin(carry_s[6]),
    .q(dig_q[6]), .q_nxt(dig_nxt[6]), .cout(carry_s[7])
  );

  always_comb begin
    state_d    = state_q;
    lap_hold_d = lap_hold_q;
    overflow_d = overflow_q;
    if (bus.clear) begin
      state_d    = ST_IDLE;
      lap_hold_d = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (roll_evt_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.start_stop) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (bus.start_stop || sat_evt_s) begin
            state_d    = ST_PAUSE;
            lap_hold_d = 1'b0;
          end else if (bus.lap) begin
            lap_hold_d = ~lap_hold_q;
          end else begin
            lap_hold_d = lap_hold_q;
          end
        end
        ST_PAUSE: begin
          if (bus.start_stop) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          lap_hold_d = 1'b0;
        end
      endcase
    end
  end

  // The display freezes only while the lap hold is set both before and after
  // this edge, so releasing the lap shows the live count immediately.
  always_comb begin
    running_d = (state_d == ST_RUN);
    if (lap_hold_q && lap_hold_d) begin
      disp_d = disp_q;
    end else begin
      disp_d = count_nxt_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lap_hold_q <= 1'b0;
      overflow_q <= 1'b0;
      running_q  <= 1'b0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      lap_hold_q <= lap_hold_d;
      overflow_q <= overflow_d;
      running_q  <= running_d;
      disp_q     <= disp_d;
    end
  end

  assign bus.disp_bcd = disp_q;
  assign bus.running  = running_q;
  assign bus.lap_hold = lap_hold_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Drives a wrapping and a saturating stopwatch with the same stimulus and
// compares both against a millisecond-count reference model.
module tb_stopwatch_core;
  import timer_pkg::*;

  localparam int MAX_MS = 3599999;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAUSE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  stopwatch_core_if bw ();
  stopwatch_core_if bs ();

  stopwatch_core #(.WRAP(1'b1)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bw));
  stopwatch_core #(.WRAP(1'b0)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));

  int n_pass = 0;
  int n_total = 0;

  // Reference model: index 0 wraps, index 1 saturates.
  int m_cnt [2];
  int m_mode [2];
  int m_disp [2];
  bit m_lap [2];
  bit m_ovf [2];

  function automatic logic [27:0] to_bcd(input int ms);
    int mn, sc, mr;
    logic [27:0] r;
    mn = ms / 60000;
    sc = (ms / 1000) % 60;
    mr = ms % 1000;
    r = {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10),
         4'(mr / 100), 4'((mr / 10) % 10), 4'(mr % 10)};
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_mode[i] = M_IDLE; m_disp[i] = 0; m_lap[i] = 1'b0; m_ovf[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit c, input bit ss, input bit lp, input bit tk);
    bit hold0, sat;
    for (int i = 0; i < 2; i++) begin
      if (c) begin
        m_cnt[i] = 0; m_mode[i] = M_IDLE; m_lap[i] = 1'b0; m_ovf[i] = 1'b0; m_disp[i] = 0;
      end else begin
        hold0 = m_lap[i];
        sat = 1'b0;
        if (m_mode[i] == M_RUN && tk) begin
          if (m_cnt[i] == MAX_MS) begin
            m_ovf[i] = 1'b1;
            if (i == 0) m_cnt[i] = 0;
            else sat = 1'b1;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
        if (m_mode[i] == M_IDLE) begin
          if (ss) m_mode[i] = M_RUN;
        end else if (m_mode[i] == M_RUN) begin
          if (ss || sat) begin
            m_mode[i] = M_PAUSE; m_lap[i] = 1'b0;
          end else if (lp) begin
            m_lap[i] = !m_lap[i];
          end
        end else begin
          if (ss) m_mode[i] = M_RUN;
        end
        if (!(hold0 && m_lap[i])) m_disp[i] = m_cnt[i];
      end
    end
  endtask

  task automatic set_in(input bit c, input bit ss, input bit lp, input bit tk);
    bw.clear = c; bw.start_stop = ss; bw.lap = lp; bw.tick_ms = tk;
    bs.clear = c; bs.start_stop = ss; bs.lap = lp; bs.tick_ms = tk;
  endtask

  // Called at a falling edge: drive, take one rising edge, return at the next falling edge.
  task automatic step(input bit c, input bit ss, input bit lp, input bit tk);
    set_in(c, ss, lp, tk);
    @(posedge clk);
    model_step(c, ss, lp, tk);
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic chk(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".w.disp"}, bw.disp_bcd, to_bcd(m_disp[0]));
    chk({tag, ".w.run"}, 28'(bw.running), 28'(m_mode[0] == M_RUN));
    chk({tag, ".w.lap"}, 28'(bw.lap_hold), 28'(m_lap[0]));
    chk({tag, ".w.ovf"}, 28'(bw.overflow), 28'(m_ovf[0]));
    chk({tag, ".s.disp"}, bs.disp_bcd, to_bcd(m_disp[1]));
    chk({tag, ".s.run"}, 28'(bs.running), 28'(m_mode[1] == M_RUN));
    chk({tag, ".s.lap"}, 28'(bs.lap_hold), 28'(m_lap[1]));
    chk({tag, ".s.ovf"}, 28'(bs.overflow), 28'(m_ovf[1]));
  endtask

  // Loads an arbitrary count into both counters; used to reach distant boundaries quickly.
  task automatic preload(input int ms);
    logic [27:0] b;
    b = to_bcd(ms);
    dut_w.u_ms_o.q_q = b[3:0];   dut_s.u_ms_o.q_q = b[3:0];
    dut_w.u_ms_t.q_q = b[7:4];   dut_s.u_ms_t.q_q = b[7:4];
    dut_w.u_ms_h.q_q = b[11:8];  dut_s.u_ms_h.q_q = b[11:8];
    dut_w.u_sec_o.q_q = b[15:12]; dut_s.u_sec_o.q_q = b[15:12];
    dut_w.u_sec_t.q_q = b[19:16]; dut_s.u_sec_t.q_q = b[19:16];
    dut_w.u_min_o.q_q = b[23:20]; dut_s.u_min_o.q_q = b[23:20];
    dut_w.u_min_t.q_q = b[27:24]; dut_s.u_min_t.q_q = b[27:24];
    m_cnt[0] = ms;
    m_cnt[1] = ms;
  endtask

  initial begin
    bit rc, rs, rl, rt;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    check_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1000);
    chk("one_second", bw.disp_bcd, 28'h0001000);
    chk("one_second_run", 28'(bw.running), 28'd1);
    check_state("one_second");

    for (int k = 0; k < 300; k++) begin
      rc = ($urandom_range(0, 49) == 0);
      rs = ($urandom_range(0, 19) == 0);
      rl = ($urandom_range(0, 14) == 0);
      rt = ($urandom_range(0, 1) == 1);
      step(rc, rs, rl, rt);
      check_state("random");
    end

    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    preload(9999);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("carry_10s", bw.disp_bcd, 28'h0010000);
    check_state("carry_10s");
    preload(59999);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("carry_1min", bw.disp_bcd, 28'h0100000);
    check_state("carry_1min");

    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    chk("pause_resume", bw.disp_bcd, 28'h0000010);
    chk("pause_resume_run", 28'(bw.running), 28'd1);
    check_state("pause_resume");

    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    preload(100);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(250);
    chk("lap_frozen", bw.disp_bcd, 28'h0000100);
    chk("lap_hold_on", 28'(bw.lap_hold), 28'd1);
    check_state("lap_frozen");
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("lap_release", bw.disp_bcd, 28'h0000350);
    check_state("lap_release");

    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    preload(MAX_MS);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("wrap_disp", bw.disp_bcd, 28'h0000000);
    chk("wrap_ovf", 28'(bw.overflow), 28'd1);
    chk("wrap_run", 28'(bw.running), 28'd1);
    chk("sat_disp", bs.disp_bcd, 28'h5959999);
    chk("sat_ovf", 28'(bs.overflow), 28'd1);
    chk("sat_run", 28'(bs.running), 28'd0);
    check_state("rollover");
    ticks(3);
    check_state("after_rollover");

    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clear_all_disp", bw.disp_bcd, 28'h0000000);
    chk("clear_all_run", 28'(bw.running), 28'd0);
    check_state("clear_all");

    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(37);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_disp", bw.disp_bcd, 28'h0000000);
    check_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_state("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
